// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and op-class helpers for the mul/div unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MADDU = 3'd5;
    localparam logic [2:0] OP_MSUB  = 3'd6;
    localparam logic [2:0] OP_MSUBU = 3'd7;

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_t;

    // Signed variants all have an even encoding.
    function automatic logic is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_sub(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring unsigned divider datapath: one quotient bit per step, operands loaded on load.
module muldiv_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] quo_q, rem_q, dsr_q;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] sub;
    logic            ge;

    // Partial remainder stays below the divisor, so the difference fits in XLEN bits.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        ge      = (shifted >= {1'b0, dsr_q});
        sub     = shifted[XLEN-1:0] - dsr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
        end else if (step) begin
            quo_q <= {quo_q[XLEN-2:0], ge};
            rem_q <= ge ? sub : shifted[XLEN-1:0];
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply / multiply-accumulate / divide unit with request and response handshakes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic            annul,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_hi,
    output logic [XLEN-1:0] resp_lo,
    output logic            stallreq
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_STEP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic              neg_res_q, neg_rem_q, div0_q;
    logic [2*XLEN-1:0] mcand_q, prod_q;
    logic [XLEN-1:0]   mplier_q, hi_q, lo_q, resp_hi_q, resp_lo_q;

    logic              accept, req_div, b_zero, a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs, quo, rem, fix_hi, fix_lo;
    logic [2*XLEN-1:0] mul_add, prod_s, acc_sum;

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StDone);
    assign stallreq   = (state_q inside {StMul, StDiv, StFix}) | (resp_valid & ~resp_ready);
    assign resp_hi    = resp_hi_q;
    assign resp_lo    = resp_lo_q;

    always_comb begin
        accept  = req_valid & req_ready & ~annul;
        req_div = is_div(req_op);
        b_zero  = (req_b == '0);
        a_neg   = is_signed(req_op) & req_a[XLEN-1];
        b_neg   = is_signed(req_op) & req_b[XLEN-1];
        a_abs   = a_neg ? -req_a : req_a;
        b_abs   = b_neg ? -req_b : req_b;
    end

    always_comb begin
        mul_add = '0;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (mplier_q[k]) mul_add = mul_add + (mcand_q << k);
        end
    end

    // Sign correction and accumulate; hi_q carries the raw dividend for divide ops.
    always_comb begin
        prod_s  = neg_res_q ? -prod_q : prod_q;
        acc_sum = is_sub(op_q) ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
        fix_hi  = prod_s[2*XLEN-1:XLEN];
        fix_lo  = prod_s[XLEN-1:0];
        if (div0_q) begin
            fix_hi = hi_q;
            fix_lo = '1;
        end else if (is_div(op_q)) begin
            fix_hi = neg_rem_q ? -rem : rem;
            fix_lo = neg_res_q ? -quo : quo;
        end else if (is_acc(op_q)) begin
            fix_hi = acc_sum[2*XLEN-1:XLEN];
            fix_lo = acc_sum[XLEN-1:0];
        end
    end

    muldiv_div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (accept & req_div & ~b_zero),
        .step     ((state_q == StDiv) & ~annul),
        .dividend (a_abs),
        .divisor  (b_abs),
        .quotient (quo),
        .remainder(rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            resp_hi_q <= '0;
            resp_lo_q <= '0;
        end else if (annul) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q      <= req_op;
                        cnt_q     <= '0;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        div0_q    <= req_div & b_zero;
                        mcand_q   <= {{XLEN{1'b0}}, a_abs};
                        mplier_q  <= b_abs;
                        prod_q    <= '0;
                        hi_q      <= req_div ? req_a : hi_i;
                        lo_q      <= lo_i;
                        state_q   <= !req_div ? StMul : (b_zero ? StFix : StDiv);
                    end
                end
                StMul: begin
                    prod_q   <= prod_q + mul_add;
                    mcand_q  <= mcand_q << MUL_STEP;
                    mplier_q <= mplier_q >> MUL_STEP;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == MUL_LAST) state_q <= StFix;
                end
                StDiv: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == DIV_LAST) state_q <= StFix;
                end
                StFix: begin
                    resp_hi_q <= fix_hi;
                    resp_lo_q <= fix_lo;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (resp_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops, handshake, annul, reset and radix sweep.
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, sw_valid, annul, resp_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b, hi_i, lo_i;
    logic        req_ready, resp_valid, stallreq;
    logic [31:0] resp_hi, resp_lo;
    logic        s1_ready, s1_valid, s1_stall, s2_ready, s2_valid, s2_stall;
    logic [31:0] s1_hi, s1_lo, s2_hi, s2_lo;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .MUL_STEP(4)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .hi_i(hi_i), .lo_i(lo_i), .annul(annul),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hi(resp_hi), .resp_lo(resp_lo),
        .stallreq(stallreq)
    );

    muldiv_unit #(.XLEN(32), .MUL_STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .req_valid(sw_valid), .req_ready(s1_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .hi_i(hi_i), .lo_i(lo_i), .annul(annul),
        .resp_valid(s1_valid), .resp_ready(resp_ready), .resp_hi(s1_hi), .resp_lo(s1_lo),
        .stallreq(s1_stall)
    );

    muldiv_unit #(.XLEN(32), .MUL_STEP(2)) u_s2 (
        .clk(clk), .rst(rst), .req_valid(sw_valid), .req_ready(s2_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .hi_i(hi_i), .lo_i(lo_i), .annul(annul),
        .resp_valid(s2_valid), .resp_ready(resp_ready), .resp_hi(s2_hi), .resp_lo(s2_lo),
        .stallreq(s2_stall)
    );

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation the first cycle each response is presented.
    initial begin
        bit   seen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid && !seen) begin
                seen = 1;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", {resp_hi, resp_lo}, 64'h0);
                    if ({resp_hi, resp_lo} == 64'h0) chk("unexpected_resp_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_hi"}, resp_hi, e.hi);
                    chk({e.name, "_lo"}, resp_lo, e.lo);
                    chk({e.name, "_lat"}, cyc - e.acc_cyc, e.lat);
                end
            end
            if (!resp_valid) seen = 0;
        end
    end

    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                         input bit push);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk({name, "_ready_timeout"}, req_ready, 1);
        req_valid = 1; req_op = op; req_a = a; req_b = b; hi_i = hi; lo_i = lo;
        @(negedge clk);
        req_valid = 0;
        req_a = 32'hDEADBEEF; req_b = 32'h0BADF00D; hi_i = '0; lo_i = '0;
        if (push) begin
            e.name = name; e.hi = ehi; e.lo = elo; e.lat = lat; e.acc_cyc = cyc;
            sb.push_back(e);
        end
        chk({name, "_req_ready_busy"}, req_ready, 0);
        chk({name, "_stall_busy"}, stallreq, 1);
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (!(req_ready && sb.size() == 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk({name, "_done_timeout"}, sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_bad;
        int l1, l2;
        logic [63:0] r1, r2;
        rst = 1; req_valid = 0; sw_valid = 0; annul = 0; resp_ready = 1;
        req_op = '0; req_a = '0; req_b = '0; hi_i = '0; lo_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_stall", stallreq, 0);
        chk("rst_result", {resp_hi, resp_lo}, 64'h0);
        rst = 0;

        issue("mult", 3'd0, 32'hFFFFFFFD, 32'd7, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 9, 1);
        wait_idle("mult");
        issue("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h1, 9, 1);
        wait_idle("multu");
        issue("div", 3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1);
        wait_idle("div");
        issue("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 0, 0, 32'h1, 32'h7FFFFFFC, 33, 1);
        wait_idle("divu");
        issue("div0", 3'd2, 32'd5, 32'd0, 0, 0, 32'h5, 32'hFFFFFFFF, 1, 1);
        wait_idle("div0");
        issue("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h80000000, 33, 1);
        wait_idle("div_ovf");
        issue("madd", 3'd4, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 9, 1);
        wait_idle("madd");
        issue("msubu", 3'd7, 32'd1, 32'd1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 9, 1);
        wait_idle("msubu");

        // Consumer back-pressure: result must hold while resp_ready is low.
        resp_ready = 0;
        issue("hold", 3'd0, 32'hFFFFFFFD, 32'd7, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 9, 1);
        for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", resp_valid, 1);
            chk("hold_stall", stallreq, 1);
            chk("hold_result", {resp_hi, resp_lo}, 64'hFFFFFFFF_FFFFFFEB);
            @(negedge clk);
        end
        resp_ready = 1;
        @(negedge clk);
        chk("hold_release_valid", resp_valid, 0);
        chk("hold_release_ready", req_ready, 1);

        // Annul mid-divide: no response may follow.
        issue("annul_divu", 3'd3, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0, 0, 0);
        repeat (9) @(negedge clk);
        annul = 1;
        @(negedge clk);
        annul = 0;
        chk("annul_ready", req_ready, 1);
        chk("annul_stall", stallreq, 0);
        seen_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) seen_bad = 1;
            @(negedge clk);
        end
        chk("annul_no_resp", seen_bad, 0);

        // Annul together with a request in IDLE: request is dropped.
        req_valid = 1; annul = 1; req_op = 3'd1; req_a = 32'd3; req_b = 32'd3;
        @(negedge clk);
        req_valid = 0; annul = 0;
        chk("annul_idle_not_accepted", req_ready, 1);

        // Asynchronous reset mid-multiply.
        issue("rst_mid", 3'd1, 32'd9, 32'd9, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_valid", resp_valid, 0);
        chk("rst_mid_stall", stallreq, 0);
        chk("rst_mid_result", {resp_hi, resp_lo}, 64'h0);
        @(negedge clk);
        rst = 0;
        issue("after_rst", 3'd1, 32'd6, 32'd7, 0, 0, 32'h0, 32'd42, 9, 1);
        wait_idle("after_rst");

        // Radix sweep on MUL_STEP=1 and MUL_STEP=2 instances.
        @(negedge clk);
        sw_valid = 1; req_op = 3'd1; req_a = 32'hFFFFFFFF; req_b = 32'hFFFFFFFF;
        @(negedge clk);
        sw_valid = 0;
        l1 = 0; l2 = 0; r1 = '0; r2 = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (s1_valid && l1 == 0) begin l1 = i; r1 = {s1_hi, s1_lo}; end
            if (s2_valid && l2 == 0) begin l2 = i; r2 = {s2_hi, s2_lo}; end
        end
        chk("sweep1_lat", l1, 33);
        chk("sweep1_result", r1, 64'hFFFFFFFE_00000001);
        chk("sweep2_lat", l2, 17);
        chk("sweep2_result", r2, 64'hFFFFFFFE_00000001);

        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
